// File: rtl/neuron_lut_writer.sv
// Loadable 2^IN_BITS x OUT_BITS lookup table for one LUT neuron.
// Sequential load through cfg_*, single-cycle-latency lookups through in_*/out_*.
module neuron_lut_writer #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  output logic                load_done,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                table_valid
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t              state, state_nxt;
  logic [IN_BITS-1:0]  addr, addr_nxt;
  logic                we;
  logic                load_done_nxt;
  logic                accept;
  logic                vld_p1;
  logic [OUT_BITS-1:0] data_p1;

  // Table storage is deliberately left unreset so it maps onto distributed RAM.
  logic [OUT_BITS-1:0] mem [DEPTH];

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    we            = 1'b0;
    load_done_nxt = 1'b0;
    case (state)
      EMPTY: begin
        if (cfg_start) begin
          state_nxt = LOAD;
          addr_nxt  = '0;
        end
      end
      LOAD: begin
        // A restart discards any coincident entry.
        if (cfg_start) begin
          addr_nxt = '0;
        end else if (cfg_valid) begin
          we       = 1'b1;
          addr_nxt = addr + 1'b1;
          if (addr == '1) begin
            state_nxt     = READY;
            load_done_nxt = 1'b1;
          end
        end
      end
      READY: begin
        if (cfg_start) begin
          state_nxt = LOAD;
          addr_nxt  = '0;
        end
      end
      default: begin
        state_nxt = EMPTY;
        addr_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      addr      <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      load_done <= load_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= cfg_data;
  end

  assign cfg_ready   = (state == LOAD);
  assign in_ready    = (state == READY);
  assign table_valid = (state == READY);
  assign accept      = in_valid & in_ready;

  // Stage p0 -> p1: registered table read; data holds when no lookup is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) data_p1 <= mem[in_data];
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

// File: tb/tb_neuron_lut_writer.sv
// Directed self-checking bench for neuron_lut_writer with hand-computed table entries.
module tb_neuron_lut_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start, cfg_valid;
  logic [1:0] cfg_data;
  logic       cfg_ready, load_done;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [1:0] out_data;
  logic       table_valid;

  int vectors    = 0;
  int miscompares = 0;
  int done_at;
  int tv_early;

  neuron_lut_writer #(.IN_BITS(8), .OUT_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .load_done(load_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .table_valid(table_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: entry = k mod 4, mode 1: all 3, mode 2: all 2.
  // stall drops cfg_valid on every third cycle. Stops after n accepted entries.
  task automatic load(input int mode, input bit stall, input int n,
                      output int done_seen, output int tv_seen);
    int acc = 0;
    done_seen = -1;
    tv_seen   = 0;
    for (int c = 0; c < 1000 && acc < n; c++) begin
      cfg_valid = !(stall && (c % 3 == 2));
      cfg_data  = (mode == 0) ? 2'(acc % 4) : (mode == 1) ? 2'b11 : 2'b10;
      tick();
      if (cfg_valid) acc++;
      if (load_done && done_seen < 0) done_seen = acc;
      if (table_valid && acc < 256) tv_seen = 1;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic start_pulse();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic look(input string tag, input logic [7:0] a, input logic [1:0] e);
    in_valid = 1'b1;
    in_data  = a;
    tick();
    in_valid = 1'b0;
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, out_data, e);
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0;
    #2;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_table_valid", table_valid, 0);
    chk("rst_load_done", load_done, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Lookups and cfg traffic are ignored while EMPTY.
    in_valid = 1'b1; in_data = 8'h10; cfg_valid = 1'b1; cfg_data = 2'b01;
    #1;
    chk("empty_in_ready", in_ready, 0);
    chk("empty_cfg_ready", cfg_ready, 0);
    tick();
    chk("empty_out_valid", out_valid, 0);
    cfg_valid = 1'b0;
    start_pulse();
    chk("load_cfg_ready", cfg_ready, 1);
    chk("load_in_ready", in_ready, 0);
    tick();
    chk("load_out_valid", out_valid, 0);
    in_valid = 1'b0;

    // Full load, entry k = k mod 4, no stalls.
    load(0, 1'b0, 256, done_at, tv_early);
    chk("full_done_at", done_at, 256);
    chk("full_table_valid", table_valid, 1);
    chk("full_in_ready", in_ready, 1);
    chk("full_cfg_ready", cfg_ready, 0);
    tick();
    chk("full_done_pulse", load_done, 0);
    look("lk00", 8'h00, 2'd0);
    look("lk05", 8'h05, 2'd1);
    look("lkFF", 8'hFF, 2'd3);

    // Back-to-back lookups: E0 -> 0, 71 -> 1, A5 -> 1.
    in_valid = 1'b1; in_data = 8'hE0; tick();
    chk("b2b_E0_vld", out_valid, 1); chk("b2b_E0", out_data, 0);
    in_data = 8'h71; tick();
    chk("b2b_71_vld", out_valid, 1); chk("b2b_71", out_data, 1);
    in_data = 8'hA5; tick();
    chk("b2b_A5_vld", out_valid, 1); chk("b2b_A5", out_data, 1);
    in_valid = 1'b0; tick();
    chk("b2b_idle_vld", out_valid, 0);
    chk("b2b_hold", out_data, 1);

    // cfg_valid in READY without cfg_start must not disturb the table.
    cfg_valid = 1'b1; cfg_data = 2'b00; tick(); tick(); cfg_valid = 1'b0;
    chk("ready_ignore_state", table_valid, 1);
    look("ready_ignore_lk", 8'h03, 2'd3);

    // Reload started with a coincident lookup and cfg_valid.
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 2'b11;
    in_valid = 1'b1; in_data = 8'h05;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0;
    chk("restart_lk_vld", out_valid, 1);
    chk("restart_lk_old", out_data, 1);
    chk("restart_table_valid", table_valid, 0);
    chk("restart_cfg_ready", cfg_ready, 1);

    // 100 entries of 2, then a restart (with a discarded entry) and a full all-3 load.
    load(2, 1'b0, 100, done_at, tv_early);
    chk("partial_no_done", done_at, -1);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 2'b00;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("restart2_table_valid", table_valid, 0);
    load(1, 1'b0, 256, done_at, tv_early);
    chk("all3_done_at", done_at, 256);
    chk("all3_tv_low", tv_early, 0);
    look("all3_00", 8'h00, 2'd3);
    look("all3_63", 8'h63, 2'd3);
    look("all3_64", 8'h64, 2'd3);
    look("all3_FF", 8'hFF, 2'd3);

    // Stalled load restores k mod 4.
    start_pulse();
    load(0, 1'b1, 256, done_at, tv_early);
    chk("stall_done_at", done_at, 256);
    chk("stall_tv_low", tv_early, 0);
    look("stall_00", 8'h00, 2'd0);
    look("stall_05", 8'h05, 2'd1);
    look("stall_02", 8'h02, 2'd2);
    look("stall_FF", 8'hFF, 2'd3);

    // Asynchronous reset after 50 entries of a new load.
    start_pulse();
    load(2, 1'b0, 50, done_at, tv_early);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cfg_ready", cfg_ready, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_table_valid", table_valid, 0);
    chk("arst_load_done", load_done, 0);
    tick();
    rst_n = 1'b1;
    cfg_valid = 1'b1; cfg_data = 2'b01;
    in_valid = 1'b1; in_data = 8'h10;
    tick(); tick();
    chk("post_rst_cfg_ready", cfg_ready, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_table_valid", table_valid, 0);
    cfg_valid = 1'b0; in_valid = 1'b0;

    start_pulse();
    load(0, 1'b0, 256, done_at, tv_early);
    chk("reload_done_at", done_at, 256);
    look("reload_A5", 8'hA5, 2'd1);
    look("reload_FE", 8'hFE, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neuron_lut_writer.md
NEURON_LUT_WRITER -- requirements
Module: neuron_lut_writer

Interface
REQ-001 SHALL have parameter IN_BITS, default 8, giving the lookup address width (table depth 2^IN_BITS).
REQ-002 SHALL have parameter OUT_BITS, default 2, giving the table entry width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_start, input, 1, single-cycle pulse that begins a table load at address 0.
REQ-006 SHALL have port cfg_valid, input, 1, cfg_data holds the next table entry.
REQ-007 SHALL have port cfg_data, input, OUT_BITS, table entry for the current load address.
REQ-008 SHALL have port cfg_ready, output, 1, the block accepts cfg_data this cycle.
REQ-009 SHALL have port load_done, output, 1, single-cycle pulse after the final entry is written.
REQ-010 SHALL have port in_valid, input, 1, lookup request qualifier.
REQ-011 SHALL have port in_data, input, IN_BITS, lookup address (packed neuron inputs).
REQ-012 SHALL have port in_ready, output, 1, lookups accepted this cycle.
REQ-013 SHALL have port out_valid, output, 1, out_data holds a lookup result.
REQ-014 SHALL have port out_data, output, OUT_BITS, registered table entry.
REQ-015 SHALL have port table_valid, output, 1, a complete table is loaded.

Function
REQ-016 SHALL store a 2^IN_BITS x OUT_BITS table in distributed RAM, written only by the load sequence.
REQ-017 SHALL implement states EMPTY, LOAD, READY; reset state EMPTY.
REQ-018 EMPTY: cfg_start -> LOAD, address counter cleared to 0; other inputs ignored.
REQ-019 LOAD: cfg_ready=1; each cycle with cfg_valid=1 writes cfg_data at the counter address, then increments the counter.
REQ-020 LOAD: write at address 2^IN_BITS-1 -> READY, counter wraps to 0, load_done=1 the following cycle, table_valid=1 from that same cycle.
REQ-021 LOAD: cfg_valid=0 cycles stall with no write and no counter change; no timeout.
REQ-022 cfg_start in LOAD or READY -> LOAD, counter=0, table_valid=0 next cycle; cfg_start wins over a coincident cfg_valid, which is discarded.
REQ-023 READY: in_ready=1, cfg_ready=0; cfg_valid without cfg_start is ignored.
REQ-024 Lookup: in_valid & in_ready in cycle N -> out_valid=1, out_data=table[in_data] in cycle N+1; latency exactly 1, one result per cycle, no backpressure on the output.
REQ-025 in_ready=0 in EMPTY and LOAD; in_valid there produces no out_valid.
REQ-026 A lookup accepted in the cycle cfg_start arrives SHALL complete normally in the next cycle with the pre-reload entry.
REQ-027 out_data SHALL hold its last value when out_valid=0.

Reset
REQ-028 rst_n low SHALL immediately force state EMPTY, counter 0, cfg_ready=0, load_done=0, in_ready=0, out_valid=0, out_data=0, table_valid=0.
REQ-029 Table contents SHALL NOT be reset; they are undefined until a complete load.
REQ-030 Reset asserted mid-LOAD SHALL abandon the load; a fresh cfg_start is required afterwards.

Verification
REQ-031 Full load, entry k = k mod 4, no stalls -> load_done exactly 256 cycles after the first accepted entry; lookups 0x00, 0x05, 0xFF -> out_data 0, 1, 3 one cycle later.
REQ-032 Load with cfg_valid dropped on every third cycle -> identical table, load_done only after the 256th accepted entry.
REQ-033 cfg_start after 100 entries, then full load of all 2'b11 -> every lookup returns 3; table_valid low from the restart until load_done.
REQ-034 in_valid=1 with in_data=0x10 in EMPTY and during LOAD -> in_ready=0, out_valid stays 0.
REQ-035 rst_n pulsed low after 50 entries -> all outputs at reset values asynchronously; state EMPTY; cfg_valid ignored until cfg_start.
REQ-036 Back-to-back lookups 0xE0, 0x71, 0xA5 in READY -> three consecutive out_valid cycles carrying the matching entries in order.
